// File: rtl/pipeline_stage_register_pkg.sv
// Shared definitions for the pipeline stage registers: the stage-register
// state enum and the packed stage payload layouts carried between stages.
package pipeline_stage_register_pkg;

  // EMPTY: nothing held. FULL: main entry valid. SKID: main and skid valid.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    FULL  = 2'd1,
    SKID  = 2'd2
  } stage_reg_state_t;

  // EX/MEM boundary payload, packed to the default 96-bit stage width.
  typedef struct packed {
    logic [31:0] alu_result;
    logic [31:0] store_data;
    logic [21:0] pc_lo;
    logic [4:0]  rd;
    logic        mem_we;
    logic        mem_re;
    logic        reg_we;
    logic [1:0]  mem_size;
  } ex_mem_payload_t;

  localparam int EX_MEM_PAYLOAD_WIDTH = $bits(ex_mem_payload_t);

endpackage

// File: rtl/pipeline_stage_register_stall_counter.sv
// Saturating event counter used to count back-pressure cycles at a stage
// boundary. Holds at all-ones once reached; cleared only by reset.
module stage_stall_counter #(
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk_i,
  input  logic                 reset_ni,
  input  logic                 inc_i,
  output logic [CNT_WIDTH-1:0] count_o
);

  // Count one per stalled cycle, never wrapping past all-ones
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      count_o <= '0;
    end else if (inc_i && (count_o != {CNT_WIDTH{1'b1}})) begin
      count_o <= count_o + CNT_WIDTH'(1);
    end
  end

endmodule

// File: rtl/pipeline_stage_register.sv
// Generic valid/ready pipeline stage register with synchronous flush and a
// saturating back-pressure counter.
//
// Build option: define PIPELINE_STAGE_SKID_EN to add a second (skid) entry so
// that ready_o comes straight from the state flops. Without it the stage is a
// single entry and ready_o = !valid_o || ready_i.
//
// Handshake: a transfer happens on a side only in a cycle where both valid
// and ready are high at the rising edge; the sender keeps data stable while
// valid is high and ready is low, and data_o never changes while
// valid_o && !ready_i.
//
// state_o is a debug view of the internal stage_reg_state_t state.
module pipeline_stage_register
  import pipeline_stage_register_pkg::*;
#(
  parameter int PAYLOAD_WIDTH = 96,
  parameter int CNT_WIDTH     = 16
) (
  input  logic                     clk_i,
  input  logic                     reset_ni,
  input  logic                     valid_i,
  output logic                     ready_o,
  input  logic [PAYLOAD_WIDTH-1:0] data_i,
  input  logic                     flush_i,
  output logic                     valid_o,
  input  logic                     ready_i,
  output logic [PAYLOAD_WIDTH-1:0] data_o,
  output logic [CNT_WIDTH-1:0]     stall_cnt_o,
  output logic [1:0]               state_o
);

  stage_reg_state_t         state_q, state_d;
  logic [PAYLOAD_WIDTH-1:0] main_q, main_d;
  logic                     in_fire, out_fire;

  assign valid_o  = (state_q != EMPTY);
  assign data_o   = main_q;
  assign state_o  = state_q;
  assign in_fire  = valid_i && ready_o;
  assign out_fire = valid_o && ready_i;

`ifdef PIPELINE_STAGE_SKID_EN
  logic [PAYLOAD_WIDTH-1:0] skid_q, skid_d;

  // Registered ready: only a full skid entry blocks upstream
  assign ready_o = (state_q != SKID);

  // Next state and entry loads; flush empties the stage and drops the input
  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    case (state_q)
      EMPTY: begin
        if (in_fire) begin
          state_d = FULL;
          main_d  = data_i;
        end
      end
      FULL: begin
        if (in_fire && out_fire) begin
          main_d = data_i;
        end else if (in_fire) begin
          state_d = SKID;
          skid_d  = data_i;
        end else if (out_fire) begin
          state_d = EMPTY;
        end
      end
      SKID: begin
        if (out_fire) begin
          state_d = FULL;
          main_d  = skid_q;
        end
      end
      default: state_d = EMPTY;
    endcase
    if (flush_i) begin
      state_d = EMPTY;
      main_d  = main_q;
      skid_d  = skid_q;
    end
  end

  // Skid entry storage
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      skid_q <= '0;
    end else begin
      skid_q <= skid_d;
    end
  end
`else
  // Single entry: accept when empty or when the held payload leaves this cycle
  assign ready_o = !valid_o || ready_i;

  // Next state and main load; flush empties the stage and drops the input
  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    case (state_q)
      EMPTY: begin
        if (in_fire) begin
          state_d = FULL;
          main_d  = data_i;
        end
      end
      FULL: begin
        if (in_fire) begin
          main_d = data_i;
        end else if (out_fire) begin
          state_d = EMPTY;
        end
      end
      default: state_d = EMPTY;
    endcase
    if (flush_i) begin
      state_d = EMPTY;
      main_d  = main_q;
    end
  end
`endif

  // State and main entry registers; reset discards held payloads at once
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q <= EMPTY;
      main_q  <= '0;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
    end
  end

  stage_stall_counter #(
    .CNT_WIDTH (CNT_WIDTH)
  ) u_stall_counter (
    .clk_i    (clk_i),
    .reset_ni (reset_ni),
    .inc_i    (valid_o && !ready_i),
    .count_o  (stall_cnt_o)
  );

endmodule

// File: tb/tb_pipeline_stage_register.sv
// Bench for pipeline_stage_register: directed scenarios plus random traffic,
// checked every cycle against a queue-based model of the stage. Works with or
// without PIPELINE_STAGE_SKID_EN.
module tb_pipeline_stage_register;

  localparam int W       = 8;
  localparam int CW      = 4;
  localparam int CNT_MAX = (1 << CW) - 1;
`ifdef PIPELINE_STAGE_SKID_EN
  localparam int DEPTH = 2;
`else
  localparam int DEPTH = 1;
`endif

  logic          clk_i    = 1'b0;
  logic          reset_ni = 1'b0;
  logic          valid_i  = 1'b0;
  logic          ready_o;
  logic [W-1:0]  data_i   = '0;
  logic          flush_i  = 1'b0;
  logic          valid_o;
  logic          ready_i  = 1'b0;
  logic [W-1:0]  data_o;
  logic [CW-1:0] stall_cnt_o;
  logic [1:0]    state_o;

  int checks = 0;
  int errors = 0;
  bit cmp_en = 1'b0;

  // model: payloads currently held, oldest first, plus the stall count
  logic [W-1:0] exp_q[$];
  int           stall_model = 0;

  pipeline_stage_register #(
    .PAYLOAD_WIDTH (W),
    .CNT_WIDTH     (CW)
  ) dut (
    .clk_i       (clk_i),
    .reset_ni    (reset_ni),
    .valid_i     (valid_i),
    .ready_o     (ready_o),
    .data_i      (data_i),
    .flush_i     (flush_i),
    .valid_o     (valid_o),
    .ready_i     (ready_i),
    .data_o      (data_o),
    .stall_cnt_o (stall_cnt_o),
    .state_o     (state_o)
  );

  // clock / reset block
  always #5 clk_i = ~clk_i;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit model_ready();
`ifdef PIPELINE_STAGE_SKID_EN
    return exp_q.size() < DEPTH;
`else
    return (exp_q.size() == 0) || ready_i;
`endif
  endfunction

  // model update at each edge: leave, then enter, then flush wipes everything
  always @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      exp_q.delete();
      stall_model = 0;
    end else begin
      bit v_now;
      bit r_now;
      v_now = exp_q.size() > 0;
      r_now = model_ready();
      if (v_now && !ready_i && stall_model < CNT_MAX) stall_model++;
      if (v_now && ready_i) void'(exp_q.pop_front());
      if (valid_i && r_now && !flush_i) exp_q.push_back(data_i);
      if (flush_i) exp_q.delete();
    end
  end

  // compare process: outputs against the model, mid-cycle
  always @(negedge clk_i) begin
    if (cmp_en && reset_ni) begin
      chk("valid_o", 32'(valid_o), 32'(exp_q.size() > 0));
      chk("ready_o", 32'(ready_o), 32'(model_ready()));
      chk("state_o", 32'(state_o), 32'(exp_q.size()));
      chk("stall_cnt_o", 32'(stall_cnt_o), 32'(stall_model));
      if (exp_q.size() > 0) chk("data_o", 32'(data_o), 32'(exp_q[0]));
    end
  end

  // driver: apply inputs for one edge, return just after it
  task automatic drive(input logic v, input logic [W-1:0] d, input logic r, input logic f);
    valid_i = v;
    data_i  = d;
    ready_i = r;
    flush_i = f;
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    // reset held with a valid input present
    valid_i = 1'b1;
    data_i  = 8'hA5;
    repeat (3) @(posedge clk_i);
    #1;
    chk("rst_valid_o", 32'(valid_o), 32'd0);
    chk("rst_data_o", 32'(data_o), 32'd0);
    chk("rst_stall", 32'(stall_cnt_o), 32'd0);
    chk("rst_ready_o", 32'(ready_o), 32'd1);
    @(negedge clk_i);
    #1;
    valid_i  = 1'b0;
    reset_ni = 1'b1;
    cmp_en   = 1'b1;

    // streaming 1,2,3 with no bubbles
    drive(1'b1, 8'd1, 1'b1, 1'b0);
    chk("stream_1", 32'(data_o), 32'd1);
    drive(1'b1, 8'd2, 1'b1, 1'b0);
    chk("stream_2", 32'(data_o), 32'd2);
    drive(1'b1, 8'd3, 1'b1, 1'b0);
    chk("stream_3", 32'(data_o), 32'd3);
    chk("stream_valid", 32'(valid_o), 32'd1);
    drive(1'b0, 8'd0, 1'b1, 1'b0);
    chk("stream_drained", 32'(valid_o), 32'd0);

    // back-pressure
    drive(1'b1, 8'h10, 1'b0, 1'b0);
    drive(1'b1, 8'h11, 1'b0, 1'b0);
    chk("bp_data_o", 32'(data_o), 32'h10);
    chk("bp_ready_o", 32'(ready_o), 32'd0);
`ifdef PIPELINE_STAGE_SKID_EN
    chk("bp_state", 32'(state_o), 32'd2);
    drive(1'b0, 8'h00, 1'b1, 1'b0);
    chk("bp_second", 32'(data_o), 32'h11);
    chk("bp_ready_back", 32'(ready_o), 32'd1);
`endif
    repeat (3) drive(1'b0, 8'h00, 1'b1, 1'b0);

    // flush while holding, with an input offered in the same cycle
    drive(1'b1, 8'h20, 1'b0, 1'b0);
`ifdef PIPELINE_STAGE_SKID_EN
    drive(1'b1, 8'h21, 1'b0, 1'b0);
`endif
    drive(1'b1, 8'h22, 1'b0, 1'b1);
    chk("flush_valid_o", 32'(valid_o), 32'd0);
    drive(1'b0, 8'h00, 1'b1, 1'b0);
    chk("flush_no_22", 32'(valid_o), 32'd0);

    // flush together with an output fire
    drive(1'b1, 8'h30, 1'b1, 1'b0);
    drive(1'b1, 8'h31, 1'b1, 1'b1);
    chk("flush_out_valid", 32'(valid_o), 32'd0);

    // counter saturation, then flush leaves it alone
    drive(1'b1, 8'h40, 1'b0, 1'b0);
    repeat (20) drive(1'b0, 8'h00, 1'b0, 1'b0);
    chk("sat_15", 32'(stall_cnt_o), 32'd15);
    drive(1'b0, 8'h00, 1'b0, 1'b1);
    chk("sat_after_flush", 32'(stall_cnt_o), 32'd15);
    drive(1'b0, 8'h00, 1'b1, 1'b0);

    // async reset to clear the counter before random traffic
    #2;
    reset_ni = 1'b0;
    #1;
    chk("rst2_stall", 32'(stall_cnt_o), 32'd0);
    @(negedge clk_i);
    #2;
    reset_ni = 1'b1;

    // random traffic, holding an offered payload until it is taken
    begin
      logic         v = 1'b0;
      logic [W-1:0] d = '0;
      for (int i = 0; i < 400; i++) begin
        logic r;
        logic f;
        if (!v || (valid_i && ready_o)) begin
          v = ($urandom_range(0, 3) != 0);
          d = W'($urandom_range(0, 255));
        end
        r = ($urandom_range(0, 2) != 0);
        f = ($urandom_range(0, 19) == 0);
        drive(v, d, r, f);
        if (f) v = 1'b0;
      end
    end

    // async reset mid-transfer, between edges
    drive(1'b1, 8'h55, 1'b0, 1'b0);
    chk("pre_async_valid", 32'(valid_o), 32'd1);
    #2;
    reset_ni = 1'b0;
    #1;
    chk("async_valid_o", 32'(valid_o), 32'd0);
    chk("async_data_o", 32'(data_o), 32'd0);
    chk("async_stall", 32'(stall_cnt_o), 32'd0);
    @(negedge clk_i);
    #2;
    reset_ni = 1'b1;
    drive(1'b1, 8'h66, 1'b1, 1'b0);
    chk("post_reset_accept", 32'(data_o), 32'h66);
    drive(1'b0, 8'h00, 1'b1, 1'b0);
    repeat (2) @(posedge clk_i);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipeline_stage_register.md
# pipeline_stage_register

Generic, parametrised pipeline stage register: the successor to the fixed EX/MEM latch. It carries one packed payload of any width between two pipeline stages under a valid/ready handshake, with synchronous flush (branch resolution) and an optional skid entry so upstream `ready_o` comes from a flop. It also provides a saturating back-pressure counter for performance monitoring. One instance sits at each stage boundary (IF/ID, ID/EX, EX/MEM, MEM/WB).

## Interface
Parameters:
- `PAYLOAD_WIDTH`, default 96: width of the packed stage payload (control, addresses, data).
- `CNT_WIDTH`, default 16: width of the stall counter.

Ports:
- `clk_i`, input, 1: the single clock; all logic is rising-edge.
- `reset_ni`, input, 1: asynchronous, active-low reset.
- `valid_i`, input, 1: upstream payload is valid.
- `ready_o`, output, 1: stage can accept a payload this cycle.
- `data_i`, input, `PAYLOAD_WIDTH`: upstream payload.
- `flush_i`, input, 1: synchronous kill of everything held and of the current input.
- `valid_o`, output, 1: downstream payload is valid.
- `ready_i`, input, 1: downstream accepts the payload.
- `data_o`, output, `PAYLOAD_WIDTH`: payload to downstream.
- `stall_cnt_o`, output, `CNT_WIDTH`: saturating count of cycles with `valid_o` high and `ready_i` low.

## Operation
- Handshakes:
  - Input fire is `valid_i && ready_o`.
  - Output fire is `valid_o && ready_i`.
  - Data moves only on fire.
  - `data_o` is held stable while `valid_o && !ready_i`.
- States (shared enum `stage_reg_state_t`):
  - EMPTY: nothing held.
  - FULL: main entry holds data.
  - SKID: main and skid entries both hold data. This state exists only with the macro defined.
- Transitions (flush has priority over all of them):
  - EMPTY: input fire → FULL, and main loads `data_i`.
  - FULL, input and output fire together → FULL, and main loads `data_i`.
  - FULL, input fire without output fire → SKID, and skid loads `data_i`.
  - FULL, output fire without input fire → EMPTY.
  - SKID, output fire → FULL, and main loads skid contents. No input is accepted in SKID.
- `valid_o` is high in FULL and SKID. `data_o` always shows the main entry, which is the oldest payload.
- `flush_i` high:
  - Next state is EMPTY and both entries are invalidated.
  - An input that fires in the same cycle is dropped.
  - An output fire in the same cycle still completes downstream.
  - The payload registers keep their values; only valid bits clear.
- Stall counter:
  - Increments by 1 on every cycle with `valid_o && !ready_i`.
  - Saturates at all-ones and never wraps.
  - Unaffected by flush; cleared only by reset.

## Timing
- Latency is 1 cycle: data accepted at edge N appears on `data_o` after edge N.
- Throughput is one payload per cycle when `ready_i` stays high.
- Asynchronous reset (`reset_ni` low) drives:
  - state to EMPTY, so `valid_o` = 0;
  - `data_o` = 0 and skid contents = 0;
  - `stall_cnt_o` = 0;
  - `ready_o` = 1 with the macro defined.
- Reset deassertion is assumed synchronised upstream. The first accept can occur at the first rising edge after deassertion.
- Reset asserted mid-transfer discards all held payloads immediately, with no clock edge needed.

## Configuration
- Macro `PIPELINE_STAGE_SKID_EN`.
- Defined:
  - Two-entry skid behaviour as described.
  - `ready_o` = (state != SKID), driven directly from state flops with no combinational path from `ready_i`.
- Undefined:
  - Single entry; the SKID state and skid register are not built.
  - `ready_o` = `!valid_o || ready_i` (combinational).
  - The FULL transition with input fire and no output fire cannot occur.
- All other behaviour is identical in both builds.

## Structure
- `stage_reg_state_t` (EMPTY/FULL/SKID) goes in the shared definitions package (GENERAL_DEFS). Stage payload struct typedefs, e.g. the EX/MEM payload packed to `PAYLOAD_WIDTH`, also go there.
- One sub-module, `stage_stall_counter`: parametrised by `CNT_WIDTH`, with inputs `clk_i`, `reset_ni` and `inc_i`, and output `count_o`. It implements the saturating counter.

## Test plan
- Reset check: hold `reset_ni`=0 with `valid_i`=1 and `data_i`=0xA5 → `valid_o`=0, `data_o`=0, `stall_cnt_o`=0. With the macro, `ready_o`=1.
- Streaming: `ready_i`=1 and payloads 1,2,3 on consecutive cycles → `data_o` shows 1,2,3 one cycle later each, with no bubbles.
- Back-pressure with the macro:
  - Send 0x10 and 0x11 while `ready_i`=0 → state SKID, `ready_o`=0, `data_o`=0x10.
  - Raise `ready_i` → 0x10 then 0x11 are delivered; `ready_o` returns to 1 after the first output fire.
- Flush:
  - In SKID with `flush_i`=1 and `valid_i`=1 (`data_i`=0x22) → next cycle `valid_o`=0 and 0x22 is never delivered.
  - Without the macro the same stimulus from FULL gives the same result.
- Counter saturation: `CNT_WIDTH`=4, `valid_o`=1, `ready_i`=0 for 20 cycles → `stall_cnt_o` reaches 15 and stays at 15.
- Async reset mid-stream: drop `reset_ni` between clock edges while FULL → `valid_o` falls before the next edge.
